// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, handler vector and
// SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] EPC_MASK     = 32'hFFFF_FFFC;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL        = 1;
  localparam int SR_IE         = 0;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle. master = pipeline side, slave = CP0.
interface cp0_if;
  logic [31:0] PC;
  logic        BD;
  logic        ExcGet;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        IntReq;

  modport master (
    output PC, BD, ExcGet, ExcCode, HWInt, A1, A2, DIn, WE, EXLClr,
    input  DOut, EPCOut, IntReq
  );

  modport slave (
    input  PC, BD, ExcGet, ExcCode, HWInt, A1, A2, DIn, WE, EXLClr,
    output DOut, EPCOut, IntReq
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID, trap decision and mfc0/mtc0/eret service.
// Optional macro CP0_BD_EN: track branch-delay slots in Cause.BD and EPC.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_4C32
) (
  input logic clk,
  input logic reset,
  cp0_if.slave bus
);

  logic [5:0]  srIm;
  logic        srExl;
  logic        srIe;
  logic [5:0]  causeIp;
  logic [4:0]  causeExc;
  logic        causeBd;
  logic [31:0] epc;

  logic        intPend;
  logic        excPend;
  logic        trap;
  logic [31:0] trapPc;

  assign intPend = srIe & ~srExl & (|(bus.HWInt & srIm));
  assign excPend = bus.ExcGet & ~srExl;
  assign trap    = intPend | excPend;

`ifdef CP0_BD_EN
  // A delay-slot fault must restart at the branch so the branch re-executes.
  assign trapPc = bus.BD ? (bus.PC - 32'd4) : bus.PC;
`else
  logic unusedBd;
  assign unusedBd = bus.BD;
  assign trapPc   = bus.PC;
  assign causeBd  = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; a trap takes precedence over mtc0/eret in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      srIm     <= '0;
      srExl    <= 1'b0;
      srIe     <= 1'b0;
      causeIp  <= '0;
      causeExc <= '0;
`ifdef CP0_BD_EN
      causeBd  <= 1'b0;
`endif
      epc      <= '0;
    end else begin
      causeIp <= bus.HWInt;
      if (trap) begin
        srExl    <= 1'b1;
        causeExc <= intPend ? EXC_INT : bus.ExcCode;
`ifdef CP0_BD_EN
        causeBd  <= bus.BD;
`endif
        epc      <= trapPc & EPC_MASK;
      end else begin
        if (bus.WE) begin
          case (bus.A2)
            REG_SR: begin
              srIm  <= bus.DIn[SR_IM_LSB +: 6];
              srExl <= bus.DIn[SR_EXL];
              srIe  <= bus.DIn[SR_IE];
            end
            REG_EPC: epc <= bus.DIn & EPC_MASK;
            default: ;
          endcase
        end
        if (bus.EXLClr) srExl <= 1'b0;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      REG_SR: begin
        bus.DOut[SR_IM_LSB +: 6] = srIm;
        bus.DOut[SR_EXL]         = srExl;
        bus.DOut[SR_IE]          = srIe;
      end
      REG_CAUSE: begin
        bus.DOut[CAUSE_BD]             = causeBd;
        bus.DOut[CAUSE_IP_LSB +: 6]    = causeIp;
        bus.DOut[CAUSE_EXC_LSB +: 5]   = causeExc;
      end
      REG_EPC:  bus.DOut = epc;
      REG_PRID: bus.DOut = PRID;
      default:  bus.DOut = '0;
    endcase
  end

  assign bus.EPCOut = epc;
  assign bus.IntReq = trap;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; expectations follow CP0_BD_EN when defined.
module tb_cp0;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vecCount  = 0;
  int   missCount = 0;

  cp0_if bus();

  cp0 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    bus.A1 = a;
    #1;
    d = bus.DOut;
  endtask

  task automatic checkReg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    readReg(a, d);
    check(tag, d, exp);
  endtask

  task automatic checkIntReq(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, bus.IntReq}, {31'd0, exp});
  endtask

  logic [31:0] expCause;
  logic [31:0] expEpc;

  initial begin
    reset      = 1'b1;
    bus.PC     = '0;
    bus.BD     = 1'b0;
    bus.ExcGet = 1'b0;
    bus.ExcCode = '0;
    bus.HWInt  = '0;
    bus.A1     = '0;
    bus.A2     = '0;
    bus.DIn    = '0;
    bus.WE     = 1'b0;
    bus.EXLClr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkReg("rst_prid", REG_PRID, 32'h0000_4C32);
    checkReg("rst_sr", REG_SR, 32'h0);
    checkReg("rst_cause", REG_CAUSE, 32'h0);
    checkReg("rst_epc", REG_EPC, 32'h0);
    checkReg("rst_other", 5'd20, 32'h0);
    checkIntReq("rst_intreq", 1'b0);
    check("rst_epcout", bus.EPCOut, 32'h0);

    // mtc0 SR <- IM[10] | IE; no bypass in the write cycle
    bus.WE = 1'b1; bus.A2 = REG_SR; bus.DIn = 32'h0000_0401;
    checkReg("sr_nobypass", REG_SR, 32'h0);
    tick();
    bus.WE = 1'b0;
    checkReg("sr_written", REG_SR, 32'h0000_0401);

    // Hardware interrupt traps in the same cycle
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_1000;
    checkIntReq("int_req", 1'b1);
    tick();
    checkReg("int_cause", REG_CAUSE, 32'h0000_0400);
    checkReg("int_sr", REG_SR, 32'h0000_0403);
    check("int_epc", bus.EPCOut, 32'h0000_1000);
    checkIntReq("int_masked_exl", 1'b0);

    // EXL=1: exception and interrupt both ignored
    bus.ExcGet = 1'b1; bus.ExcCode = EXC_ADES; bus.PC = 32'h0000_2000;
    checkIntReq("exl_block", 1'b0);
    tick();
    check("exl_epc_hold", bus.EPCOut, 32'h0000_1000);
    checkReg("exl_cause_hold", REG_CAUSE, 32'h0000_0400);

    // eret clears EXL; pending interrupt fires the next cycle
    bus.ExcGet = 1'b0; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    checkReg("eret_sr", REG_SR, 32'h0000_0401);
    checkIntReq("eret_int", 1'b1);
    tick();
    check("eret_int_epc", bus.EPCOut, 32'h0000_2000);
    bus.HWInt = '0; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    checkReg("clr_cause", REG_CAUSE, 32'h0);

    // Exception in a delay slot
    bus.ExcGet = 1'b1; bus.ExcCode = EXC_ADES; bus.PC = 32'h0000_3010; bus.BD = 1'b1;
    checkIntReq("exc_req", 1'b1);
    tick();
`ifdef CP0_BD_EN
    expCause = 32'h8000_0014; expEpc = 32'h0000_300C;
`else
    expCause = 32'h0000_0014; expEpc = 32'h0000_3010;
`endif
    checkReg("exc_cause", REG_CAUSE, expCause);
    check("exc_epc", bus.EPCOut, expEpc);
    bus.ExcGet = 1'b0; bus.BD = 1'b0; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;

    // Trap beats a same-cycle mtc0 to EPC
    bus.ExcGet = 1'b1; bus.ExcCode = EXC_ADEL; bus.PC = 32'h0000_4000;
    bus.WE = 1'b1; bus.A2 = REG_EPC; bus.DIn = 32'hDEAD_BEEF;
    tick();
    bus.ExcGet = 1'b0; bus.WE = 1'b0;
    check("trap_wins_epc", bus.EPCOut, 32'h0000_4000);
    checkReg("trap_wins_cause", REG_CAUSE, 32'h0000_0010);
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;

    // SR only keeps its defined fields; Cause is not writable
    bus.WE = 1'b1; bus.A2 = REG_SR; bus.DIn = 32'hFFFF_FFFF;
    tick();
    checkReg("sr_fields", REG_SR, 32'h0000_FC03);
    bus.A2 = REG_CAUSE;
    tick();
    checkReg("cause_ro", REG_CAUSE, 32'h0000_0010);
    bus.A2 = REG_SR; bus.DIn = 32'h0000_0401;
    tick();

    // mtc0 EPC forces low bits to zero
    bus.A2 = REG_EPC; bus.DIn = 32'h0000_3007;
    tick();
    bus.WE = 1'b0;
    check("epc_align", bus.EPCOut, 32'h0000_3004);

    // Reset in the same cycle as a trap clears everything
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_5000;
    checkIntReq("pre_rst_int", 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkReg("rst_trap_sr", REG_SR, 32'h0);
    checkReg("rst_trap_cause", REG_CAUSE, 32'h0);
    check("rst_trap_epc", bus.EPCOut, 32'h0);
    checkIntReq("rst_trap_intreq", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 unit directly downstream of the M-stage exception checker. Consumes the merged per-instruction exception flag/code and external hardware interrupt lines, decides when the pipeline must trap, and holds the architectural SR, Cause, EPC and PrID registers. It also serves `mfc0`/`mtc0`/`eret` from the M stage. Its trap request flushes the pipeline and redirects fetch to the handler.

## Interface
- `PRID`, 32'h0000_4C32: read-only value of PrID (reg 15).
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `PC` in 32: PC of the instruction currently in M.
- `BD` in 1: M instruction sits in a branch delay slot.
- `ExcGet` in 1: exception present on M instruction (from exception checker).
- `ExcCode` in 5: exception code, valid when `ExcGet`.
- `HWInt` in 6: level-sensitive hardware interrupt lines.
- `A1` in 5: read register number (`mfc0` rd).
- `A2` in 5: write register number (`mtc0` rd).
- `DIn` in 32: `mtc0` write data.
- `WE` in 1: `mtc0` write enable.
- `EXLClr` in 1: `eret` in M; clears SR.EXL.
- `DOut` out 32: combinational read of register `A1`.
- `EPCOut` out 32: current EPC, for `eret` redirect.
- `IntReq` out 1: trap now (flush + jump to handler 32'h0000_4180).

## Operation
- SR (12): IM = bits[15:10], EXL = bit[1], IE = bit[0]; other bits read 0.
- Cause (13): BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]; other bits 0. Not writable by `mtc0`.
- EPC (14): 32-bit, bits[1:0] always 0. PrID (15): constant `PRID`. Any other `A1` reads 0.
- `IntPend = SR.IE & ~SR.EXL & |(HWInt & SR.IM)`; `ExcPend = ExcGet & ~SR.EXL`; `IntReq = IntPend | ExcPend` (combinational, same cycle).
- Priority: interrupt over exception. On trap edge: EXL←1; Cause.ExcCode ← 0 if `IntPend`, else `ExcCode`; Cause.BD ← `BD`; EPC ← trap PC (see Configuration), bits[1:0] forced 0.
- Cause.IP ← `HWInt` every cycle, unconditionally (including trap cycles).
- `WE` with no trap: `A2`=12 writes SR fields from `DIn`; `A2`=14 writes EPC = {`DIn`[31:2],2'b0}; other `A2` ignored.
- `EXLClr` with no trap: EXL←0.
- Simultaneous trap and `WE`/`EXLClr`: trap wins; write/clear dropped (faulting instruction is nullified).
- `ExcGet` while EXL=1: ignored, no state change, `IntReq`=0.

## Timing
- Reset: SR=0, Cause=0, EPC=0; hence `IntReq`=0, `EPCOut`=0, `DOut`=0 except `A1`=15 → `PRID`.
- `IntReq`, `DOut`, `EPCOut`: zero-latency combinational from current state and inputs.
- Register effects visible one cycle after the edge; `mtc0` to SR enabling IE with pending `HWInt` raises `IntReq` the next cycle.
- No read bypass: `DOut` in the `mtc0` cycle returns old value.
- `reset` asserted mid-trap overrides all updates that edge.

## Configuration
- `CP0_BD_EN` defined: Cause.BD tracks `BD`; trap PC = `PC`−4 when `BD`=1, else `PC`.
- Not defined: `BD` ignored, Cause.BD reads 0, trap PC = `PC`.

## Structure
- Shared package/define: CP0 register numbers (12/13/14/15), ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), handler address 32'h0000_4180, SR/Cause field bit positions.
- Single flat module; no sub-module needed.

## Test plan
- Reset, then `A1`=15 → `DOut`=32'h0000_4C32; `A1`=12/13/14 → 0; `IntReq`=0.
- `mtc0` SR←32'h0000_0401 (IM[10], IE); next cycle `HWInt`=6'b000001 → `IntReq`=1 same cycle; after edge Cause.ExcCode=0, EXL=1, EPC=`PC`, `IntReq`=0.
- `ExcGet`=1, `ExcCode`=5, `PC`=32'h0000_3010, `BD`=1 → `IntReq`=1; after edge Cause=32'h8000_0014 (with `CP0_BD_EN`), EPC=32'h0000_300C; without macro Cause=32'h0000_0014, EPC=32'h0000_3010.
- EXL=1, `ExcGet`=1 and `HWInt` active → `IntReq`=0, no register change; `EXLClr`=1 → EXL=0, next cycle interrupt `IntReq`=1.
- Same cycle `ExcGet`=1 (code 4) and `WE`=1,`A2`=14,`DIn`=32'hDEAD_BEEF → EPC=`PC`, not 32'hDEAD_BEEC; Cause.ExcCode=4.
- `mtc0` EPC←32'h0000_3007 → `EPCOut`=32'h0000_3004; `reset` same cycle as trap → all registers 0.
